rv32_bram_arbiter: RTL and testbench
====================================

Name: rv32_bram_arbiter

Overview:
- Sequences and shares one single-ported-per-direction block RAM (1 write port, 1 registered read port, word writes only, 1-cycle read latency) between two requesters of the multicycle RV32 core: the instruction-fetch port (read-only) and the load/store port (read/write with byte enables).
- Sub-word stores are performed as read-modify-write, because the RAM has no byte enables.
- Sits between the core's fetch/LSU and the RAM wrapper. The RAM's write and read clocks are both tied to clk.

Parameters:
- WORD_SIZE, 32, data width in bits; must be 32.
- ADDR_SIZE, 8, RAM word-address width; requester byte addresses are ADDR_SIZE+2 bits wide.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_SIZE+2  fetch byte address; bits [1:0] ignored.
- if_resp_valid  out  1  fetch data valid, one-cycle pulse.
- if_resp_rdata  out  32  fetch data.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted.
- d_req_we  in  1  1 = store.
- d_req_be  in  4  store byte enables; bit i covers byte i.
- d_req_addr  in  ADDR_SIZE+2  data byte address; bits [1:0] ignored.
- d_req_wdata  in  32  store data, already lane-aligned.
- d_resp_valid  out  1  load data / store ack, one-cycle pulse.
- d_resp_rdata  out  32  load data; 0 for store acks.
- bram_wen  out  1  RAM write enable.
- bram_waddr  out  ADDR_SIZE  RAM write address.
- bram_wdata  out  32  RAM write data.
- bram_ren  out  1  RAM read enable.
- bram_raddr  out  ADDR_SIZE  RAM read address.
- bram_rdata  in  32  RAM registered read data.

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM in IDLE.
  - All ready, valid and enable outputs 0; all address and data outputs 0.
  - last_grant = DATA.
- Handshake rules:
  - Requests may only be accepted in IDLE.
  - req_ready is combinational and is asserted only to the arbitration winner whose valid is high.
  - Transfer occurs at the edge where valid & ready are both 1.
  - Requester holds valid and payload stable until ready.
  - Responses have no backpressure.
- On accept, latch owner, word address (addr[ADDR_SIZE+1:2]), we, be and wdata.
- FSM states and transitions:
  - IDLE -> RD on accepted read (fetch, or data with we = 0).
  - IDLE -> WR on a store with be = 1111.
  - IDLE -> RMW_RD on a store with be ∉ {0000, 1111}.
  - IDLE -> RESP on a store with be = 0000; no RAM access.
  - RD: bram_ren = 1 with latched raddr; -> RESP.
  - WR: bram_wen = 1, wdata = latched wdata; -> RESP.
  - RMW_RD: bram_ren = 1; -> RMW_WR.
  - RMW_WR: bram_wen = 1, wdata = per-byte merge (be[i] ? latched wdata byte i : bram_rdata byte i); -> RESP.
  - RESP: owner's resp_valid = 1. rdata = bram_rdata for reads, 0 for stores; rdata = 0 whenever resp_valid = 0. -> IDLE.
- Latency from accept edge N:
  - Read: resp_valid in cycle N+2.
  - Full-word store: ack in cycle N+2.
  - RMW store: ack in cycle N+3.
  - be = 0000 store: ack in cycle N+1.
  - Back-to-back issue spacing is one cycle longer than the latency, because of the return to IDLE.
- Each bram_ren / bram_wen pulse lasts exactly one cycle per access; wen and ren are never asserted together.
- Arbitration (both valid in IDLE) is per the optional feature. A single valid requester always wins. last_grant updates on every accept.
- Reset mid-operation:
  - FSM returns asynchronously to IDLE and wen drops immediately, so no partial write occurs if reset precedes the edge.
  - The pending request is discarded with no response.

Optional Feature:
- Macro RV32_BRAM_ARB_RR_EN.
- Defined: round-robin; on a tie, grant the requester not in last_grant. The first tie after reset goes to fetch.
- Undefined: fixed priority, data port always wins ties; last_grant is still kept but unused.

Decomposition:
- Package rv32_bram_arb_pkg:
  - state enum {IDLE, RD, WR, RMW_RD, RMW_WR, RESP};
  - owner enum {OWN_IF, OWN_D};
  - constant BE_FULL = 4'b1111;
  - function byte_merge(old, new, be).
- Sub-module rv32_arb2 (2-way grant logic plus last_grant register, macro-controlled) is natural; the FSM stays in the top module.

Test Plan:
1. Preload word 4 = 0xDEADBEEF; fetch addr 0x10 accepted at cycle N -> bram_ren=1, raddr=4 in N+1; if_resp_valid=1, rdata=0xDEADBEEF in N+2; d_resp_valid stays 0.
2. Store be=1111, addr 0x20, wdata 0x12345678 -> single wen cycle with waddr=8, ack at N+2 with rdata 0; a subsequent load returns 0x12345678.
3. Word 8 = 0x11223344; store be=0100, wdata 0x00AB0000 -> one ren cycle, then one wen cycle with wdata 0x11AB3344; ack at N+3.
4. Both valid continuously for 4 requests -> with macro, grants alternate IF, D, IF, D; without macro, all 4 go to D while IF ready stays 0.
5. Assert rst_n=0 during RMW_RD -> wen never pulses, word unchanged, all outputs 0; after release, a fetch is accepted normally.
6. Store be=0000 -> d_resp_valid at N+1; no ren and no wen.

Source files
------------

// File: rtl/rv32_bram_arb_pkg.sv
// Shared types and helpers for the RV32 block-RAM arbiter.
// Used by rv32_arb2 and rv32_bram_arbiter. RV32_BRAM_ARB_RR_EN selects round-robin ties.
package rv32_bram_arb_pkg;

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    localparam logic [3:0] BE_FULL = 4'b1111;

    // Lanes with be[i] set take the store data; the rest keep the RAM word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rv32_arb2.sv
// Two-way fetch/data grant plus last_grant history.
// RV32_BRAM_ARB_RR_EN: round-robin ties; otherwise the data port wins every tie.
module rv32_arb2
    import rv32_bram_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   req_if,
    input  logic   req_d,
    output logic   gnt_if,
    output logic   gnt_d,
    output owner_e last_grant
);

    logic tie_to_if;

    always_comb begin
`ifdef RV32_BRAM_ARB_RR_EN
        tie_to_if = (last_grant == OWN_D);
`else
        tie_to_if = 1'b0;
`endif
    end

    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (en) begin
            if (req_if && req_d) begin
                gnt_if = tie_to_if;
                gnt_d  = !tie_to_if;
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= OWN_D;
        else if (gnt_if) last_grant <= OWN_IF;
        else if (gnt_d)  last_grant <= OWN_D;
    end

endmodule

// File: rtl/rv32_bram_arbiter.sv
// Shares one block RAM between the RV32 fetch and load/store ports; sub-word stores use read-modify-write.
// Tie arbitration is round-robin when RV32_BRAM_ARB_RR_EN is defined, data-first otherwise.
module rv32_bram_arbiter
    import rv32_bram_arb_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [ADDR_SIZE+1:0] if_req_addr,
    output logic                 if_resp_valid,
    output logic [WORD_SIZE-1:0] if_resp_rdata,
    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic                 d_req_we,
    input  logic [3:0]           d_req_be,
    input  logic [ADDR_SIZE+1:0] d_req_addr,
    input  logic [WORD_SIZE-1:0] d_req_wdata,
    output logic                 d_resp_valid,
    output logic [WORD_SIZE-1:0] d_resp_rdata,
    output logic                 bram_wen,
    output logic [ADDR_SIZE-1:0] bram_waddr,
    output logic [WORD_SIZE-1:0] bram_wdata,
    output logic                 bram_ren,
    output logic [ADDR_SIZE-1:0] bram_raddr,
    input  logic [WORD_SIZE-1:0] bram_rdata
);

    state_e               state, state_nxt;
    owner_e               owner;
    logic                 accept_en;
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [WORD_SIZE-1:0] wdata_q;

    always_comb accept_en = (state == IDLE) && rst_n;

    // last_grant changes only on accept, so it doubles as the latched owner.
    rv32_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (accept_en),
        .req_if     (if_req_valid),
        .req_d      (d_req_valid),
        .gnt_if     (if_req_ready),
        .gnt_d      (d_req_ready),
        .last_grant (owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (if_req_ready) begin
                addr_q  <= if_req_addr[ADDR_SIZE+1:2];
                we_q    <= 1'b0;
                be_q    <= '0;
                wdata_q <= '0;
            end else if (d_req_ready) begin
                addr_q  <= d_req_addr[ADDR_SIZE+1:2];
                we_q    <= d_req_we;
                be_q    <= d_req_be;
                wdata_q <= d_req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bram_ren      = 1'b0;
        bram_raddr    = '0;
        bram_wen      = 1'b0;
        bram_waddr    = '0;
        bram_wdata    = '0;
        if_resp_valid = 1'b0;
        if_resp_rdata = '0;
        d_resp_valid  = 1'b0;
        d_resp_rdata  = '0;
        unique case (state)
            IDLE: begin
                if (if_req_ready) begin
                    state_nxt = RD;
                end else if (d_req_ready) begin
                    if (!d_req_we)                state_nxt = RD;
                    else if (d_req_be == BE_FULL) state_nxt = WR;
                    else if (d_req_be == 4'b0000) state_nxt = RESP;
                    else                          state_nxt = RMW_RD;
                end
            end
            RD: begin
                bram_ren   = 1'b1;
                bram_raddr = addr_q;
                state_nxt  = RESP;
            end
            WR: begin
                bram_wen   = 1'b1;
                bram_waddr = addr_q;
                bram_wdata = wdata_q;
                state_nxt  = RESP;
            end
            RMW_RD: begin
                bram_ren   = 1'b1;
                bram_raddr = addr_q;
                state_nxt  = RMW_WR;
            end
            RMW_WR: begin
                bram_wen   = 1'b1;
                bram_waddr = addr_q;
                bram_wdata = byte_merge(bram_rdata, wdata_q, be_q);
                state_nxt  = RESP;
            end
            RESP: begin
                if (owner == OWN_IF) begin
                    if_resp_valid = 1'b1;
                    if_resp_rdata = bram_rdata;
                end else begin
                    d_resp_valid = 1'b1;
                    d_resp_rdata = we_q ? '0 : bram_rdata;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32_bram_arbiter.sv
// Randomized self-checking bench for rv32_bram_arbiter against a transaction-level schedule model.
// Honours RV32_BRAM_ARB_RR_EN for the expected tie-break rule.
module tb_rv32_bram_arbiter;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW+1:0] if_req_addr;
    logic [31:0]   if_resp_rdata;
    logic          d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [3:0]    d_req_be;
    logic [AW+1:0] d_req_addr;
    logic [31:0]   d_req_wdata, d_resp_rdata;
    logic          bram_wen, bram_ren;
    logic [AW-1:0] bram_waddr, bram_raddr;
    logic [31:0]   bram_wdata, bram_rdata;

    always #5 clk = ~clk;

    rv32_bram_arbiter #(.WORD_SIZE(32), .ADDR_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_be(d_req_be), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata)
    );

    // RAM wrapper stand-in: word writes, registered read, plus a preload port.
    logic [31:0] ram [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en)         ram[ld_addr] <= ld_data;
        else if (bram_wen) ram[bram_waddr] <= bram_wdata;
        if (bram_ren) bram_rdata <= ram[bram_raddr];
    end

    // Reference: memory contents plus per-cycle expected events, filled when a request is accepted.
    logic [31:0] ref_mem [16];
    logic        e_ren [8], e_wen [8], e_ifv [8], e_dv [8];
    logic [7:0]  e_raddr [8], e_waddr [8];
    logic [31:0] e_wdata [8], e_data [8];
    int unsigned cyc = 0, busy_until = 0;
    logic        m_last_d = 1'b1;
    int unsigned n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 8; i++) begin
            e_ren[i] = 0; e_wen[i] = 0; e_ifv[i] = 0; e_dv[i] = 0;
            e_raddr[i] = '0; e_waddr[i] = '0; e_wdata[i] = '0; e_data[i] = '0;
        end
    endtask

    function automatic int unsigned sl(input int unsigned k);
        return (cyc + k) % 8;
    endfunction

    task automatic sched_resp(input logic is_if, input int unsigned k, input logic [31:0] data);
        if (is_if) e_ifv[sl(k)] = 1'b1; else e_dv[sl(k)] = 1'b1;
        e_data[sl(k)] = data;
    endtask

    task automatic model_accept(input logic is_if, input logic we, input logic [3:0] be,
                                input logic [9:0] addr, input logic [31:0] wd);
        logic [7:0]  w;
        logic [31:0] merged;
        w = addr[9:2];
        m_last_d = !is_if;
        if (!we) begin
            e_ren[sl(1)] = 1'b1; e_raddr[sl(1)] = w;
            sched_resp(is_if, 2, ref_mem[w[3:0]]);
            busy_until = cyc + 3;
        end else if (be == 4'hF) begin
            e_wen[sl(1)] = 1'b1; e_waddr[sl(1)] = w; e_wdata[sl(1)] = wd;
            ref_mem[w[3:0]] = wd;
            sched_resp(1'b0, 2, 32'h0);
            busy_until = cyc + 3;
        end else if (be == 4'h0) begin
            sched_resp(1'b0, 1, 32'h0);
            busy_until = cyc + 2;
        end else begin
            for (int i = 0; i < 4; i++)
                merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : ref_mem[w[3:0]][8*i +: 8];
            e_ren[sl(1)] = 1'b1; e_raddr[sl(1)] = w;
            e_wen[sl(2)] = 1'b1; e_waddr[sl(2)] = w; e_wdata[sl(2)] = merged;
            ref_mem[w[3:0]] = merged;
            sched_resp(1'b0, 3, 32'h0);
            busy_until = cyc + 4;
        end
    endtask

    // One clock: compare at the falling edge, then advance past the rising edge.
    task automatic step();
        int unsigned s;
        logic gi, gd;
        @(negedge clk);
        s = cyc % 8;
        gi = 1'b0; gd = 1'b0;
        if (cyc >= busy_until) begin
            if (if_req_valid && d_req_valid) begin
`ifdef RV32_BRAM_ARB_RR_EN
                if (m_last_d) gi = 1'b1; else gd = 1'b1;
`else
                gd = 1'b1;
`endif
            end else begin
                gi = if_req_valid;
                gd = d_req_valid;
            end
        end
        check("if_ready", 32'(if_req_ready), 32'(gi));
        check("d_ready", 32'(d_req_ready), 32'(gd));
        check("ren", 32'(bram_ren), 32'(e_ren[s]));
        check("wen", 32'(bram_wen), 32'(e_wen[s]));
        if (e_ren[s]) check("raddr", 32'(bram_raddr), 32'(e_raddr[s]));
        if (e_wen[s]) begin
            check("waddr", 32'(bram_waddr), 32'(e_waddr[s]));
            check("wdata", bram_wdata, e_wdata[s]);
        end
        check("if_resp_valid", 32'(if_resp_valid), 32'(e_ifv[s]));
        check("if_resp_rdata", if_resp_rdata, e_ifv[s] ? e_data[s] : 32'h0);
        check("d_resp_valid", 32'(d_resp_valid), 32'(e_dv[s]));
        check("d_resp_rdata", d_resp_rdata, e_dv[s] ? e_data[s] : 32'h0);
        e_ren[s] = 0; e_wen[s] = 0; e_ifv[s] = 0; e_dv[s] = 0;
        if (gi) model_accept(1'b1, 1'b0, 4'h0, if_req_addr, 32'h0);
        if (gd) model_accept(1'b0, d_req_we, d_req_be, d_req_addr, d_req_wdata);
        @(posedge clk);
        #1;
        cyc++;
        if (gi) if_req_valid = 1'b0;
        if (gd) d_req_valid = 1'b0;
    endtask

    task automatic issue_if(input logic [9:0] a);
        if_req_valid = 1'b1; if_req_addr = a;
    endtask

    task automatic issue_d(input logic we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd);
        d_req_valid = 1'b1; d_req_we = we; d_req_be = be; d_req_addr = a; d_req_wdata = wd;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (if_req_valid || d_req_valid || cyc < busy_until); i++) step();
        check("drain_timeout", 32'(if_req_valid || d_req_valid || cyc < busy_until), 32'h0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_ready"}, 32'(if_req_ready), 32'h0);
        check({tag, "_d_ready"}, 32'(d_req_ready), 32'h0);
        check({tag, "_ren"}, 32'(bram_ren), 32'h0);
        check({tag, "_wen"}, 32'(bram_wen), 32'h0);
        check({tag, "_raddr"}, 32'(bram_raddr), 32'h0);
        check({tag, "_waddr"}, 32'(bram_waddr), 32'h0);
        check({tag, "_wdata"}, bram_wdata, 32'h0);
        check({tag, "_if_resp"}, 32'(if_resp_valid), 32'h0);
        check({tag, "_if_rdata"}, if_resp_rdata, 32'h0);
        check({tag, "_d_resp"}, 32'(d_resp_valid), 32'h0);
        check({tag, "_d_rdata"}, d_resp_rdata, 32'h0);
    endtask

    function automatic logic [9:0] rnd_addr();
        logic [9:0] a;
        a = 10'($urandom);
        a[9:6] = 4'h0;
        return a;
    endfunction

    function automatic logic [3:0] rnd_be();
        int unsigned r;
        r = $urandom_range(0, 5);
        if (r == 0) return 4'h0;
        if (r == 1) return 4'hF;
        return 4'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int unsigned n_acc;
        clear_sched();
        rst_n = 1'b0;
        // Valids held high during reset: readiness must stay low regardless.
        if_req_valid = 1'b1; if_req_addr = 10'h010;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'hF; d_req_addr = 10'h020; d_req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ld_en = 1'b1; ld_addr = 8'(i);
            ld_data = (i == 4) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = ld_data;
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        check_quiet("reset");
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        rst_n = 1'b1;

        issue_if(10'h010); drain();                      // fetch word 4
        issue_d(1'b1, 4'hF, 10'h020, 32'h12345678); drain();
        issue_d(1'b0, 4'h0, 10'h020, 32'h0); drain();
        issue_d(1'b1, 4'hF, 10'h021, 32'h11223344); drain();
        issue_d(1'b1, 4'b0100, 10'h020, 32'h00AB0000); drain();
        issue_d(1'b0, 4'h0, 10'h022, 32'h0); drain();
        issue_d(1'b1, 4'h0, 10'h020, 32'hFFFFFFFF); drain();

        n_acc = 0;
        for (int i = 0; i < 40 && n_acc < 4; i++) begin
            if (!if_req_valid) issue_if(rnd_addr());
            if (!d_req_valid) issue_d(1'b0, 4'h0, rnd_addr(), 32'h0);
            step();
            if (!if_req_valid || !d_req_valid) n_acc++;
        end
        check("tie_accepts", n_acc, 32'd4);
        drain();

        // Reset while the RMW read is in flight: no write, no response.
        saved = ref_mem[3];
        issue_d(1'b1, 4'b0010, 10'h00C, 32'h00005500);
        step();
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check("rst_word", ram[3], saved);
        ref_mem[3] = saved;
        clear_sched();
        busy_until = 0;
        m_last_d = 1'b1;
        rst_n = 1'b1;
        issue_if(10'h00C); drain();

        for (int i = 0; i < 400; i++) begin
            if (!if_req_valid && $urandom_range(0, 2) == 0) issue_if(rnd_addr());
            if (!d_req_valid && $urandom_range(0, 1) == 0)
                issue_d(1'($urandom), rnd_be(), rnd_addr(), $urandom);
            step();
        end
        drain();
        for (int i = 0; i < 16; i++) check("final_mem", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
